// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter in front of the mem_ctrl command port: one transaction in flight,
// completion detected from mc_command, per-requester response pulse, stalled requests time out.
module mem_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0]          req_rdnwr,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_err,
  output logic                        mc_cmd_n,
  output logic                        mc_rdnwr,
  output logic [ADDR_W-1:0]           mc_addr,
  output logic [DATA_W-1:0]           mc_data_in,
  output logic                        mc_data_in_vld,
  input  logic [2:0]                  mc_command,
  input  logic [DATA_W-1:0]           mc_data_out,
  output logic                        busy
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [2:0]         CMD_READ   = 3'b010;
  localparam logic [2:0]         CMD_WRITE  = 3'b011;
  localparam logic [NUM_REQ-1:0] ZERO_REQ   = {NUM_REQ{1'b0}};
  localparam logic [NUM_REQ-1:0] ONE_REQ    = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0]      TIMER_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0]      TIMER_ONE  = TW'(1);
  localparam logic [TW-1:0]      TIMER_MAX  = {TW{1'b1}};
  localparam logic [TW-1:0]      TIMER_LIM  = TW'(TIMEOUT);
  localparam logic [GW-1:0]      GRANT_INIT = GW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t              state_r, state_next_s;
  logic [GW-1:0]       last_grant_r, last_grant_next_s;
  logic [GW-1:0]       owner_r, owner_next_s;
  logic                rdnwr_r, rdnwr_next_s;
  logic [ADDR_W-1:0]   addr_r, addr_next_s;
  logic [DATA_W-1:0]   wdata_r, wdata_next_s;
  logic [TW-1:0]       timer_r, timer_next_s;
  logic [DATA_W-1:0]   rdata_r, rdata_next_s;
  logic                err_r, err_next_s;
  logic [NUM_REQ-1:0]  rsp_valid_r, rsp_valid_next_s;
  logic                mc_cmd_n_r, mc_cmd_n_next_s;
  logic                data_in_vld_r, data_in_vld_next_s;
  logic                busy_r, busy_next_s;

  logic [GW-1:0]       grant_s;
  logic                found_s;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    logic [GW-1:0] idx_v;
    logic          hit_v;
    grant_s = last_grant_r;
    found_s = 1'b0;
    idx_v   = last_grant_r;
    hit_v   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_v   = GW'((int'(last_grant_r) + k) % NUM_REQ);
      hit_v   = !found_s && req_valid[idx_v];
      grant_s = hit_v ? idx_v : grant_s;
      found_s = found_s | hit_v;
    end
  end

  assign req_ready = ((state_r == IDLE) && found_s) ? (ONE_REQ << grant_s) : ZERO_REQ;

  // Next-state and next register values; outputs are registered from the next state.
  always_comb begin
    state_next_s      = state_r;
    last_grant_next_s = last_grant_r;
    owner_next_s      = owner_r;
    rdnwr_next_s      = rdnwr_r;
    addr_next_s       = addr_r;
    wdata_next_s      = wdata_r;
    timer_next_s      = timer_r;
    rdata_next_s      = rdata_r;
    err_next_s        = err_r;

    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_next_s      = ISSUE;
          owner_next_s      = grant_s;
          last_grant_next_s = grant_s;
          rdnwr_next_s      = req_rdnwr[grant_s];
          addr_next_s       = req_addr[grant_s*ADDR_W +: ADDR_W];
          wdata_next_s      = req_wdata[grant_s*DATA_W +: DATA_W];
          timer_next_s      = TIMER_ZERO;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        // A command that does not match the transaction direction is ignored.
        if (!rdnwr_r && (mc_command == CMD_WRITE)) begin
          state_next_s = RESP;
          rdata_next_s = {DATA_W{1'b0}};
          err_next_s   = 1'b0;
        end else if (rdnwr_r && (mc_command == CMD_READ)) begin
          state_next_s = CAPTURE;
        end else if (timer_r == TIMER_LIM) begin
          state_next_s = RESP;
          rdata_next_s = {DATA_W{1'b0}};
          err_next_s   = 1'b1;
        end else begin
          timer_next_s = (timer_r == TIMER_MAX) ? timer_r : (timer_r + TIMER_ONE);
        end
      end
      CAPTURE: begin
        state_next_s = RESP;
        rdata_next_s = mc_data_out;
        err_next_s   = 1'b0;
      end
      RESP: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase

    mc_cmd_n_next_s    = (state_next_s != ISSUE);
    data_in_vld_next_s = (state_next_s == ISSUE) && !rdnwr_next_s;
    busy_next_s        = (state_next_s != IDLE);
    rsp_valid_next_s   = (state_next_s == RESP) ? (ONE_REQ << owner_next_s) : ZERO_REQ;
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      last_grant_r  <= GRANT_INIT;
      owner_r       <= {GW{1'b0}};
      rdnwr_r       <= 1'b0;
      addr_r        <= {ADDR_W{1'b0}};
      wdata_r       <= {DATA_W{1'b0}};
      timer_r       <= TIMER_ZERO;
      rdata_r       <= {DATA_W{1'b0}};
      err_r         <= 1'b0;
      rsp_valid_r   <= ZERO_REQ;
      mc_cmd_n_r    <= 1'b1;
      data_in_vld_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      last_grant_r  <= last_grant_next_s;
      owner_r       <= owner_next_s;
      rdnwr_r       <= rdnwr_next_s;
      addr_r        <= addr_next_s;
      wdata_r       <= wdata_next_s;
      timer_r       <= timer_next_s;
      rdata_r       <= rdata_next_s;
      err_r         <= err_next_s;
      rsp_valid_r   <= rsp_valid_next_s;
      mc_cmd_n_r    <= mc_cmd_n_next_s;
      data_in_vld_r <= data_in_vld_next_s;
      busy_r        <= busy_next_s;
    end
  end

  assign rsp_valid      = rsp_valid_r;
  assign rsp_rdata      = rdata_r;
  assign rsp_err        = err_r;
  assign mc_cmd_n       = mc_cmd_n_r;
  assign mc_rdnwr       = rdnwr_r;
  assign mc_addr        = addr_r;
  assign mc_data_in     = wdata_r;
  assign mc_data_in_vld = data_in_vld_r;
  assign busy           = busy_r;

endmodule

// Protocol checker: a requester must hold req_valid until accepted; grants and responses one-hot.
module mem_req_arbiter_chk #(
  parameter int NUM_REQ = 4
) (
  input logic               clk,
  input logic               rst_n,
  input logic [NUM_REQ-1:0] req_valid,
  input logic [NUM_REQ-1:0] req_ready,
  input logic [NUM_REQ-1:0] rsp_valid
);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_hold
    a_valid_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (req_valid[i] && !req_ready[i]) |=> req_valid[i]);
  end

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
  a_rsp_onehot:   assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rsp_valid));

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: expected responses queued at grant, compared at response.
module tb_mem_req_arbiter;

  localparam int NR = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid, req_ready, req_rdnwr, rsp_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [DW-1:0]     rsp_rdata, mc_data_in, mc_data_out;
  logic              rsp_err, mc_cmd_n, mc_rdnwr, mc_data_in_vld, busy;
  logic [AW-1:0]     mc_addr;
  logic [2:0]        mc_command;

  typedef struct {
    logic [NR-1:0] vld;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t sb_q[$];
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  mem_req_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rdnwr(req_rdnwr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mc_cmd_n(mc_cmd_n), .mc_rdnwr(mc_rdnwr), .mc_addr(mc_addr),
    .mc_data_in(mc_data_in), .mc_data_in_vld(mc_data_in_vld),
    .mc_command(mc_command), .mc_data_out(mc_data_out), .busy(busy)
  );

  mem_req_arbiter_chk #(.NUM_REQ(NR)) u_chk (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .rsp_valid(rsp_valid)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]           = 1'b1;
    req_rdnwr[i]           = rd;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
  endtask

  // Grant, issue and complete one transaction; n = ISSUE cycle of completion, 0 = never.
  task automatic serve(input int owner, input logic rd, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input int n, input logic [DW-1:0] rdat,
                       input bit hold);
    int            k;
    int            c;
    exp_t          e;
    logic [NR-1:0] oh;
    oh = 4'b0001 << owner;
    #1;
    k = 0;
    while (req_ready == 4'b0000 && k < 50) begin
      @(negedge clk); #1; k++;
    end
    check("grant", req_ready, oh);
    e.vld   = oh;
    e.err   = (n == 0);
    e.rdata = (rd && n > 0) ? rdat : 32'h0;
    sb_q.push_back(e);
    @(negedge clk);
    if (!hold) req_valid[owner] = 1'b0;
    check("issue_cmd_n", mc_cmd_n, 1'b0);
    check("issue_busy", busy, 1'b1);
    check("issue_addr", mc_addr, a);
    check("issue_rdnwr", mc_rdnwr, rd);
    check("issue_wdata", mc_data_in, wd);
    check("issue_wvld", mc_data_in_vld, !rd);
    check("issue_ready_low", req_ready, 4'b0000);
    if (n > 0) begin
      for (c = 1; c < n; c++) @(negedge clk);
      mc_command = rd ? 3'b010 : 3'b011;
      @(negedge clk);
      mc_command = 3'b000;
      if (rd) begin
        check("capture_cmd_n", mc_cmd_n, 1'b1);
        mc_data_out = rdat;
        @(negedge clk);
        mc_data_out = 32'h0;
      end
    end else begin
      c = 0;
      while (rsp_valid == 4'b0000 && c < 40) begin
        @(negedge clk); c++;
        mc_command = (c == 1) ? (rd ? 3'b011 : 3'b010) : 3'b000;
      end
      mc_command = 3'b000;
      check("timeout_cycles", c, TO + 1);
    end
    check("sb_depth", sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("rsp_valid", rsp_valid, e.vld);
      check("rsp_rdata", rsp_rdata, e.rdata);
      check("rsp_err", rsp_err, e.err);
    end
    check("resp_addr_hold", mc_addr, a);
    check("resp_cmd_n", mc_cmd_n, 1'b1);
    @(negedge clk);
    check("rsp_pulse", rsp_valid, 4'b0000);
    check("idle_busy", busy, 1'b0);
    check("rdata_hold", rsp_rdata, e.rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    req_valid   = 4'b0000;
    req_rdnwr   = 4'b0000;
    req_addr    = 64'h0;
    req_wdata   = 128'h0;
    mc_command  = 3'b000;
    mc_data_out = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_cmd_n", mc_cmd_n, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, 4'b0000);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_err", rsp_err, 1'b0);
    check("rst_addr", mc_addr, 16'h0);
    check("rst_wvld", mc_data_in_vld, 1'b0);
    check("rst_ready", req_ready, 4'b0000);
    rst_n = 1'b1;
    @(negedge clk);

    // Write from req0 completing on the 3rd ISSUE cycle.
    set_req(0, 1'b0, 16'h1234, 32'hDEADBEEF);
    serve(0, 1'b0, 16'h1234, 32'hDEADBEEF, 3, 32'h0, 1'b0);

    // Read from req2 with data one cycle after READ.
    set_req(2, 1'b1, 16'h00FF, 32'h0);
    serve(2, 1'b1, 16'h00FF, 32'h0, 2, 32'hCAFE0001, 1'b0);

    // req1 waits while req3 is in service, then is accepted next.
    set_req(3, 1'b0, 16'h3333, 32'h0BADF00D);
    set_req(1, 1'b1, 16'h1111, 32'h0);
    serve(3, 1'b0, 16'h3333, 32'h0BADF00D, 4, 32'h0, 1'b0);
    serve(1, 1'b1, 16'h1111, 32'h0, 1, 32'h5A5AA5A5, 1'b0);

    // Completion in the same cycle the timer reaches the limit wins.
    set_req(2, 1'b0, 16'h2222, 32'h22222222);
    serve(2, 1'b0, 16'h2222, 32'h22222222, TO + 1, 32'h0, 1'b0);

    // Read that never completes (one mismatched WRITE ignored) times out.
    set_req(0, 1'b1, 16'h0BEE, 32'h0);
    serve(0, 1'b1, 16'h0BEE, 32'h0, 0, 32'h0, 1'b0);

    // Reset while in ISSUE abandons the transaction.
    set_req(2, 1'b1, 16'h4444, 32'h0);
    #1;
    check("rst_mid_grant", req_ready, 4'b0100);
    @(negedge clk);
    req_valid[2] = 1'b0;
    check("rst_mid_issue", mc_cmd_n, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_cmd_n", mc_cmd_n, 1'b1);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_rsp", rsp_valid, 4'b0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_no_rsp", rsp_valid, 4'b0000);
    check("rst_sb_empty", sb_q.size(), 0);

    // All four requesting: order 0,1,2,3,0 with req0 re-requesting.
    set_req(0, 1'b0, 16'hA000, 32'hA0A0A0A0);
    set_req(1, 1'b1, 16'hA001, 32'h0);
    set_req(2, 1'b0, 16'hA002, 32'hA2A2A2A2);
    set_req(3, 1'b1, 16'hA003, 32'h0);
    serve(0, 1'b0, 16'hA000, 32'hA0A0A0A0, 1, 32'h0, 1'b1);
    serve(1, 1'b1, 16'hA001, 32'h0, 2, 32'h11110001, 1'b0);
    serve(2, 1'b0, 16'hA002, 32'hA2A2A2A2, 2, 32'h0, 1'b0);
    serve(3, 1'b1, 16'hA003, 32'h0, 3, 32'h33330003, 1'b0);
    serve(0, 1'b0, 16'hA000, 32'hA0A0A0A0, 1, 32'h0, 1'b0);

    check("end_sb_empty", sb_q.size(), 0);
    check("end_idle", busy, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
